shared_mem_arbiter: RTL
=======================

// Module: shared_mem_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one single-port shared memory among N_CORES gpu cores.
//  Each core raises a level request (load or store) with a held address and store data.
//  The arbiter serialises one access at a time and returns read data plus a one-cycle val_data pulse.
//  It sits between the core array and the shared memory macro.
// PARAMETERS
//  N_CORES  16  number of requesting cores (>=2)
//  ADDR_W   12  shared memory address width
//  DATA_W   8   data width
//  MEM_LAT  1   memory read latency in cycles after the sm_en cycle (>=1)
// PORTS
//  clk            in   1                single clock, all state updates on posedge
//  reset          in   1                asynchronous, active-high
//  core_req_ld    in   N_CORES          per-core load request, level, held until val_data
//  core_req_st    in   N_CORES          per-core store request, level, held until val_data
//  core_addr      in   N_CORES*ADDR_W   per-core address, core k at [k*ADDR_W +: ADDR_W]
//  core_wdata     in   N_CORES*DATA_W   per-core store data, core k at [k*DATA_W +: DATA_W]
//  core_val_data  out  N_CORES          one-hot, one-cycle completion pulse (load and store)
//  core_rdata     out  DATA_W           broadcast read data, valid while core_val_data != 0
//  sm_en          out  1                memory access strobe, one cycle per transaction
//  sm_we          out  1                1 = write, qualified by sm_en
//  sm_addr        out  ADDR_W           memory address
//  sm_wdata       out  DATA_W           memory write data
//  sm_rdata       in   DATA_W           memory read data, valid MEM_LAT cycles after the sm_en cycle
//  busy           out  1                transaction in flight (state != IDLE)
//  grant_id       out  clog2(N_CORES)   index of the core currently or last granted
//  proto_err      out  1                sticky: a granted core had ld and st high together
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; rr pointer=N_CORES-1, so core 0 wins first.
//  Reset mid-transaction aborts it: no sm_en, no val_data, and the request is not replayed by the arbiter.
//  FSM:
//   IDLE : req = core_req_ld|core_req_st.
//          If req!=0, pick the first set bit searching from ptr+1 and wrapping modulo N_CORES.
//          Latch k, addr, wdata and is_st (=st & ~ld). Set ptr=k, grant_id=k. Go to ISSUE.
//   ISSUE: one cycle with sm_en=1, sm_we=is_st, sm_addr/sm_wdata=latched values.
//          Store -> RESP. Load -> WAIT.
//   WAIT : count MEM_LAT cycles. On the edge ending the last cycle, capture sm_rdata into core_rdata. Go to RESP.
//   RESP : core_val_data[k]=1 for exactly one cycle. Go to IDLE.
//          The core drops its request on this edge, so core k is never re-granted from a stale request.
//  sm_en, sm_we, sm_addr, sm_wdata are 0 outside ISSUE.
//  Latency from request first seen in IDLE to val_data:
//   load  = 2+MEM_LAT cycles (IDLE, ISSUE, MEM_LAT x WAIT, then RESP).
//   store = 2 cycles.
//  Throughput: at most one transaction per 3+MEM_LAT cycles (load), per 3 cycles (store).
//  Requests arriving while busy wait. Only the IDLE-cycle snapshot arbitrates; no preemption.
//  A request dropped before RESP still completes, and its val_data still pulses.
//  Loads and stores are not distinguished for priority; arbitration uses rotation order only.
//  core_rdata holds the last load value. Stores do not change it.
//  core_req_ld & core_req_st both set on the granted core: load is performed and proto_err is set (cleared only by reset).
//  Pointer wraps N_CORES-1 -> 0. The core just served has the lowest priority in the next arbitration.
// TESTING
//  1 Load, MEM_LAT=1: core 3 ld addr 0x0A5, mem returns 0x5C
//    -> sm_en=1 sm_we=0 sm_addr=0x0A5 in cycle 1; core_val_data=0x0008 and core_rdata=0x5C in cycle 3.
//  2 Store: core 7 st addr 0x123 data 0xEE
//    -> one cycle with sm_en=1 sm_we=1 sm_addr=0x123 sm_wdata=0xEE; core_val_data[7] pulses next cycle; core_rdata unchanged.
//  3 All 16 cores load from reset, each dropping its request after its pulse
//    -> grants 0..15 in order, exactly one pulse each, 16*(3+MEM_LAT) cycles total, no duplicate grant.
//  4 Fairness: after core 5 served, cores 2 and 9 request together -> 9 granted first, then 2.
//  5 Core 1 ld and st both set -> load executed (sm_we=0), val_data[1] pulses, proto_err=1 and stays 1.
//  6 reset pulsed during WAIT (MEM_LAT=3) -> all outputs 0 immediately, no val_data.
//    A later core 4 load completes normally with grant order restarting from core 0.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Round-robin sequencer giving N_CORES cores serialised access to one single-port shared memory.
// Latency: load 2+MEM_LAT cycles, store 2 cycles, from request seen in IDLE to the core_val_data pulse.
// Backpressure: requests are level-held by the cores; while busy, new requests wait; one access in flight.
module shared_mem_arbiter #(
    parameter int N_CORES = 16,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1,
    localparam int ID_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        core_req_ld,
    input  logic [N_CORES-1:0]        core_req_st,
    input  logic [N_CORES*ADDR_W-1:0] core_addr,
    input  logic [N_CORES*DATA_W-1:0] core_wdata,
    output logic [N_CORES-1:0]        core_val_data,
    output logic [DATA_W-1:0]         core_rdata,
    output logic                      sm_en,
    output logic                      sm_we,
    output logic [ADDR_W-1:0]         sm_addr,
    output logic [DATA_W-1:0]         sm_wdata,
    input  logic [DATA_W-1:0]         sm_rdata,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      proto_err
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(N_CORES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;

    // r_ptr doubles as the index of the core being served: it is only updated on a grant.
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_grant;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_is_st;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_proto;

    logic [N_CORES-1:0] w_req;
    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W-1:0]    w_idx;
    logic [ADDR_W-1:0]  w_addr_arr  [N_CORES];
    logic [DATA_W-1:0]  w_wdata_arr [N_CORES];

    assign w_req = core_req_ld | core_req_st;

    genvar g;
    generate
        for (g = 0; g < N_CORES; g++) begin : g_unpack
            assign w_addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
            assign w_wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Rotating priority search: first requester after the last granted core, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= N_CORES; i++) begin
            w_idx = ID_W'((int'(r_ptr) + i) % N_CORES);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and memory/completion strobes, all decoded from the current state.
    always_comb begin
        w_next        = r_state;
        sm_en         = 1'b0;
        sm_we         = 1'b0;
        sm_addr       = '0;
        sm_wdata      = '0;
        core_val_data = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sm_en    = 1'b1;
                sm_we    = r_is_st;
                sm_addr  = r_addr;
                sm_wdata = r_wdata;
                w_next   = r_is_st ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                core_val_data[r_ptr] = 1'b1;
                w_next               = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Grant snapshot, read-latency counter, read data capture and sticky protocol error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= PTR_RST;
            r_grant <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_st <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_proto <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ptr   <= w_pick;
                        r_grant <= w_pick;
                        r_addr  <= w_addr_arr[w_pick];
                        r_wdata <= w_wdata_arr[w_pick];
                        // A core asserting both is served as a load.
                        r_is_st <= core_req_st[w_pick] & ~core_req_ld[w_pick];
                        if (core_req_st[w_pick] && core_req_ld[w_pick]) begin
                            r_proto <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_rdata <= sm_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign grant_id   = r_grant;
    assign core_rdata = r_rdata;
    assign proto_err  = r_proto;

endmodule
